// File: rtl/layernorm_scale_requant.sv
// LayerNorm scale/requantise stage: (x - mean) * inv_std, rounded half-up,
// saturated to OUT_W bits, with row framing regenerated from an internal counter.
module layernorm_scale_requant #(
  parameter int SHIFT   = 14,
  parameter int OUT_W   = 16,
  parameter int ROW_LEN = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic signed [21:0]      in_diff,
  input  logic        [14:0]      in_inv_std,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_row
);

  localparam int CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(ROW_LEN - 1);
  localparam logic signed [37:0] RND     = 38'sd1 <<< (SHIFT - 1);
  localparam logic signed [37:0] SAT_MAX = (38'sd1 <<< (OUT_W - 1)) - 38'sd1;
  localparam logic signed [37:0] SAT_MIN = ~SAT_MAX;

  logic signed [36:0]      p1_q, p1_d;
  logic                    v1_q, v1_d, last1_q, last1_d;
  logic signed [37:0]      r2_q, r2_d;
  logic                    v2_q, v2_d, last2_q, last2_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    advance;
  logic                    accept;
  logic                    row_end;
  logic signed [36:0]      prod;
  logic signed [37:0]      sum;
  logic signed [37:0]      rnd;

  assign advance   = out_ready || !out_valid_q;
  assign in_ready  = advance;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign err_row   = err_q;

  always_comb begin
    p1_d        = p1_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    r2_d        = r2_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    // Both operands widened to 37 bits so the signed product is exact
    prod    = $signed({{15{in_diff[21]}}, in_diff}) * $signed({22'd0, in_inv_std});
    sum     = $signed({p1_q[36], p1_q}) + RND;
    rnd     = sum >>> SHIFT;
    row_end = (cnt_q == CNT_MAX);
    accept  = in_valid && advance;

    // An explicit in_last always resynchronises the row counter
    if (accept) begin
      cnt_d = (in_last || row_end) ? '0 : cnt_q + 1'b1;
      if (in_last != row_end) err_d = 1'b1;
    end

    if (advance) begin
      v1_d = in_valid;
      if (in_valid) begin
        p1_d    = prod;
        last1_d = row_end;
      end
      v2_d        = v1_q;
      r2_d        = rnd;
      last2_d     = last1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_last_d = last2_q;
        if (r2_q > SAT_MAX) begin
          out_data_d = SAT_MAX[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else if (r2_q < SAT_MIN) begin
          out_data_d = SAT_MIN[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = r2_q[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      p1_q        <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      r2_q        <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      r2_q        <= r2_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_layernorm_scale_requant.sv
// Randomised and directed bench for layernorm_scale_requant; expected beats come
// from an arithmetic reference model held in a queue.
module tb_layernorm_scale_requant;

  localparam int SHIFT   = 14;
  localparam int OUT_W   = 16;
  localparam int ROW_LEN = 8;

  logic                    ap_clk;
  logic                    ap_rst_n;
  logic signed [21:0]      in_diff;
  logic        [14:0]      in_inv_std;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_row;

  layernorm_scale_requant #(.SHIFT(SHIFT), .OUT_W(OUT_W), .ROW_LEN(ROW_LEN)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_diff   (in_diff),
    .in_inv_std(in_inv_std),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_row   (err_row)
  );

  typedef struct {
    longint data;
    bit     sat;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     first_out_cyc = -1;
  int     row_idx = 0;
  bit     exp_err = 1'b0;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Reference: exact product, floor((p + 2^(SHIFT-1)) / 2^SHIFT), then clamp
  function automatic exp_t refModel(input longint d, input longint inv, input bit last);
    exp_t   e;
    longint num, den, q, hi, lo;
    num = d * inv + (longint'(1) << (SHIFT - 1));
    den = longint'(1) << SHIFT;
    q   = num / den;
    if (num < 0 && q * den != num) q = q - 1;
    hi  = (longint'(1) << (OUT_W - 1)) - 1;
    lo  = -(longint'(1) << (OUT_W - 1));
    e.sat  = (q > hi) || (q < lo);
    e.data = (q > hi) ? hi : ((q < lo) ? lo : q);
    e.last = last;
    return e;
  endfunction

  task automatic applyStimulus(input bit v, input int d, input int inv, input bit last,
                               input bit ordy, output bit acc);
    bit   emit;
    exp_t e;
    @(negedge ap_clk);
    in_valid   = v;
    in_diff    = v ? d[21:0] : 22'($urandom);
    in_inv_std = v ? inv[14:0] : 15'($urandom);
    in_last    = v ? last : 1'($urandom);
    out_ready  = ordy;
    #1;
    cyc++;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
    checkOutput("err_row", err_row, exp_err);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", out_valid, 0);
      end else begin
        checkOutput("out_data", longint'(out_data), exp_q[0].data);
        checkOutput("out_sat", out_sat, exp_q[0].sat);
        checkOutput("out_last", out_last, exp_q[0].last);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        if (emit) void'(exp_q.pop_front());
      end
    end
    if (acc) begin
      e = refModel(longint'(d), longint'(inv), row_idx == ROW_LEN - 1);
      if (last != (row_idx == ROW_LEN - 1)) exp_err = 1'b1;
      row_idx = last ? 0 : (row_idx + 1) % ROW_LEN;
      exp_q.push_back(e);
    end
  endtask

  task automatic sendBeat(input int d, input int inv, input bit last);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) applyStimulus(1'b1, d, inv, last, 1'b1, acc);
    checkOutput("beat_accepted", acc, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, acc);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  task automatic resetDut();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    exp_q.delete();
    exp_err       = 1'b0;
    row_idx       = 0;
    first_out_cyc = -1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_err_row", err_row, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_data", longint'(out_data), 0);
  endtask

  initial begin
    bit acc;
    int acc_cyc;
    int bi;
    int bits_last;
    int d;
    int inv;
    bit lst;
    ap_rst_n   = 1'b0;
    in_valid   = 1'b0;
    in_diff    = '0;
    in_inv_std = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    resetDut();

    // Unity gain and accept-to-output latency
    applyStimulus(1'b1, 1000, 16384, 1'b0, 1'b1, acc);
    checkOutput("unity_accept", acc, 1);
    acc_cyc = cyc;
    repeat (5) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, acc);
    checkOutput("latency", first_out_cyc - acc_cyc, 3);
    checkOutput("unity_drained", exp_q.size(), 0);

    // Rounding and saturation corners
    sendBeat(3, 8192, 1'b0);
    sendBeat(-3, 8192, 1'b0);
    sendBeat(1, 8191, 1'b0);
    sendBeat(2097151, 32767, 1'b0);
    sendBeat(-2097152, 32767, 1'b0);
    drain();

    // Eight back-to-back beats with downstream stalled on cycles 4-7
    resetDut();
    bi = 0;
    for (int c = 1; c <= 40 && bi < 8; c++) begin
      applyStimulus(1'b1, (bi + 1) * 111 - 400, 16384 + bi * 37, bi == 7,
                    !(c >= 4 && c <= 7), acc);
      if (acc) bi++;
    end
    checkOutput("bp_all_accepted", bi, 8);
    drain();

    // Row framing: two clean rows, then an early in_last, then a clean row
    resetDut();
    for (int b = 1; b <= 16; b++) sendBeat(b * 5, 16384, (b % 8) == 0);
    drain();
    checkOutput("frame_clean", err_row, 0);
    for (int b = 1; b <= 3; b++) sendBeat(b, 16384, b == 3);
    for (int b = 1; b <= 8; b++) sendBeat(b, 16384, b == 8);
    drain();
    checkOutput("frame_err_sticky", err_row, 1);

    // Randomised traffic with random backpressure and occasional bad framing
    resetDut();
    for (int c = 0; c < 400; c++) begin
      bits_last = int'($urandom_range(0, 99));
      d   = int'($urandom_range(0, 4194303)) - 2097152;
      if ($urandom_range(0, 3) == 0) d = d / 64;
      inv = int'($urandom_range(0, 32767));
      lst = (row_idx == ROW_LEN - 1);
      if (bits_last < 3) lst = !lst;
      applyStimulus($urandom_range(0, 3) != 0, d, inv, lst, $urandom_range(0, 9) < 7, acc);
    end
    drain();

    // Reset with beats in flight: nothing stale may appear afterwards
    applyStimulus(1'b1, 10, 16384, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 20, 16384, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 30, 16384, 1'b0, 1'b1, acc);
    resetDut();
    repeat (8) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, acc);
    sendBeat(-1000, 16384, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
